// File: rtl/loader_pkg.sv
// Shared definitions for the boot-time instruction loader.
//
// Contents:
//   BYTES_PER_WORD - stream bytes per 32-bit little-endian word
//   BYTE_IDX_W     - width of the byte-within-word counter
//   byte_idx_t     - byte-within-word counter type
//   load_state_t   - loader FSM states (header, data, checksum, done, error)
//   is_streaming   - true in the states that accept stream bytes
package loader_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned BYTE_IDX_W     = 2;

  typedef logic [BYTE_IDX_W-1:0] byte_idx_t;

  typedef enum logic [2:0] {
    ST_HDR,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } load_state_t;

  function automatic logic is_streaming(input load_state_t s);
    return (s == ST_HDR) || (s == ST_DATA) || (s == ST_CSUM);
  endfunction

endpackage

// File: rtl/byte_assembler.sv
// Little-endian byte-to-word assembler.
//
// Collects four accepted bytes, LSB first, into a 32-bit word. On the cycle
// the fourth byte is accepted, word_valid is high and word already carries
// that byte in bits [31:24], so the consumer can register the complete word
// on the same edge that accepts its last byte.
//
// Ports:
//   clk        - system clock, rising edge
//   clear      - synchronous clear of byte counter and partial word
//   byte_in    - stream byte
//   accept     - byte_in is transferred this cycle
//   word_valid - fourth byte of a word is being accepted this cycle
//   word       - assembled word, valid while word_valid is high
module byte_assembler
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        clear,
  input  logic [7:0]  byte_in,
  input  logic        accept,
  output logic        word_valid,
  output logic [31:0] word
);

  byte_idx_t   idx;
  logic [23:0] partial;
  logic        last_byte;

  assign last_byte = (idx == byte_idx_t'(BYTES_PER_WORD - 1));

  // Only the lower three bytes are stored; the top byte is taken straight
  // from byte_in when the word completes.
  always_ff @(posedge clk) begin
    if (clear) begin
      idx     <= '0;
      partial <= '0;
    end else if (accept) begin
      idx <= idx + 1'b1;
      case (idx)
        2'd0:    partial[7:0]   <= byte_in;
        2'd1:    partial[15:8]  <= byte_in;
        2'd2:    partial[23:16] <= byte_in;
        default: ;
      endcase
    end
  end

  always_comb begin
    word_valid = accept && last_byte;
    word       = {byte_in, partial};
  end

endmodule

// File: rtl/instr_loader.sv
// Boot-time program loader for the CPU instruction RAM.
//
// Receives a byte stream (header N, N data words, XOR trailer; all fields
// little-endian 32-bit), writes the data words into instruction memory from
// BASE_ADDR upward and releases the CPU from reset only when the trailer
// matches the XOR of the data words. Oversize headers and checksum
// mismatches park the loader in an error state until rst.
//
// Parameters:
//   ADDR_WIDTH - word-address width of instruction memory (2**ADDR_WIDTH words)
//   BASE_ADDR  - first word address written
//
// Ports:
//   clk       - system clock, rising edge
//   rst       - synchronous, active-high reset
//   byteIn    - stream data byte
//   byteValid - byteIn valid this cycle
//   byteReady - loader accepts a byte this cycle
//   memWEn    - one-cycle instruction-memory write enable
//   memAddr   - word address of the write
//   memData   - word to write
//   cpuRst    - holds the CPU in reset until the load succeeds
//   loadDone  - load completed with matching checksum
//   loadErr   - load failed (oversize header or checksum mismatch)
//   wordCount - number of data words written so far
module instr_loader
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            byteIn,
  input  logic                  byteValid,
  output logic                  byteReady,
  output logic                  memWEn,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic [31:0]           memData,
  output logic                  cpuRst,
  output logic                  loadDone,
  output logic                  loadErr,
  output logic [ADDR_WIDTH:0]   wordCount
);

  localparam logic [32:0]           MAX_WORDS = 33'(1) << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] BASE      = ADDR_WIDTH'(BASE_ADDR);

  load_state_t         state;
  load_state_t         state_next;
  logic                accept;
  logic                word_valid;
  logic [31:0]         word;
  logic [ADDR_WIDTH:0] n_words;
  logic [31:0]         csum;
  logic                hdr_oversize;
  logic                hdr_empty;
  logic                last_word;

  assign accept = byteValid && byteReady;

  byte_assembler u_asm (
    .clk        (clk),
    .clear      (rst),
    .byte_in    (byteIn),
    .accept     (accept),
    .word_valid (word_valid),
    .word       (word)
  );

  // Header is compared at full 32-bit width so that values that alias to a
  // legal count after truncation are still rejected.
  assign hdr_oversize = {1'b0, word} > MAX_WORDS;
  assign hdr_empty    = (word == '0);
  // wordCount doubles as the word index; the write being accepted now is
  // the last one when the post-increment count reaches N.
  assign last_word    = ((wordCount + 1'b1) == n_words);

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_HDR;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      ST_HDR: begin
        if (word_valid) begin
          if (hdr_oversize) begin
            state_next = ST_ERR;
          end else if (hdr_empty) begin
            state_next = ST_CSUM;
          end else begin
            state_next = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (word_valid && last_word) begin
          state_next = ST_CSUM;
        end
      end
      ST_CSUM: begin
        if (word_valid) begin
          state_next = (word == csum) ? ST_DONE : ST_ERR;
        end
      end
      ST_DONE: state_next = ST_DONE;
      ST_ERR:  state_next = ST_ERR;
      default: state_next = ST_ERR;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: state-decoded outputs
  // ---------------------------------------------------------------------
  always_comb begin
    byteReady = is_streaming(state) && !rst;
    loadDone  = 1'b0;
    loadErr   = 1'b0;
    cpuRst    = 1'b1;
    case (state)
      ST_DONE: begin
        loadDone = 1'b1;
        cpuRst   = 1'b0;
      end
      ST_ERR:  loadErr = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath: word count, checksum and memory write registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      n_words   <= '0;
      csum      <= '0;
      wordCount <= '0;
      memWEn    <= 1'b0;
      memAddr   <= '0;
      memData   <= '0;
    end else begin
      memWEn <= 1'b0;
      if (word_valid) begin
        case (state)
          ST_HDR: n_words <= word[ADDR_WIDTH:0];
          ST_DATA: begin
            memWEn    <= 1'b1;
            memAddr   <= BASE + wordCount[ADDR_WIDTH-1:0];
            memData   <= word;
            wordCount <= wordCount + 1'b1;
            csum      <= csum ^ word;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader. Two instances share one byte
// stream: a default-sized one (1024 words, base 0) and a tiny one
// (4 words, base 3) that exposes oversize headers, exact fill and address
// wrap. Expected results come from a stream-parsing reference model.
module tb_instr_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] byte_in = '0;
  logic       byte_valid = 1'b0;

  logic        rdy0, wen0, cr0, dn0, er0;
  logic [9:0]  addr0;
  logic [31:0] data0;
  logic [10:0] wc0;

  logic        rdy1, wen1, cr1, dn1, er1;
  logic [1:0]  addr1;
  logic [31:0] data1;
  logic [2:0]  wc1;

  instr_loader #(.ADDR_WIDTH(10), .BASE_ADDR(0)) dut0 (
    .clk(clk), .rst(rst), .byteIn(byte_in), .byteValid(byte_valid),
    .byteReady(rdy0), .memWEn(wen0), .memAddr(addr0), .memData(data0),
    .cpuRst(cr0), .loadDone(dn0), .loadErr(er0), .wordCount(wc0)
  );

  instr_loader #(.ADDR_WIDTH(2), .BASE_ADDR(3)) dut1 (
    .clk(clk), .rst(rst), .byteIn(byte_in), .byteValid(byte_valid),
    .byteReady(rdy1), .memWEn(wen1), .memAddr(addr1), .memData(data1),
    .cpuRst(cr1), .loadDone(dn1), .loadErr(er1), .wordCount(wc1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]  stim[$];
  logic [63:0] mon_wr0[$];
  logic [63:0] mon_wr1[$];
  logic [1:0]  inv_bad = 2'b00;
  int          cr_low0 = 0;
  int          cr_low1 = 0;
  int          mon_start[2];

  logic [63:0] exp_w[2][0:63];
  int          exp_n[2];
  logic [19:0] exp_st[2];
  int          obs_n[2];
  logic [19:0] obs_st[2];

  // Monitor: capture write pulses and track output invariants.
  always @(negedge clk) begin
    if (wen0) mon_wr0.push_back({32'(addr0), data0});
    if (wen1) mon_wr1.push_back({32'(addr1), data1});
    if ((dn0 && er0) || (cr0 !== !dn0)) inv_bad[0] <= 1'b1;
    if ((dn1 && er1) || (cr1 !== !dn1)) inv_bad[1] <= 1'b1;
    if (cr0 === 1'b0) cr_low0 <= cr_low0 + 1;
    if (cr1 === 1'b0) cr_low1 <= cr_low1 + 1;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] get_word(input int unsigned p);
    return {stim[p+3], stim[p+2], stim[p+1], stim[p]};
  endfunction

  function automatic logic [63:0] obs_wr(input int d, input int i);
    return (d == 0) ? mon_wr0[mon_start[0] + i] : mon_wr1[mon_start[1] + i];
  endfunction

  task automatic push_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) stim.push_back(w[8*k +: 8]);
  endtask

  // Reference: parse the stream as far as it goes for a memory of maxw words.
  task automatic model(input int d);
    int unsigned maxw, base, n, nb, wc;
    logic [31:0] acc, w;
    logic done, err;
    maxw = (d == 0) ? 1024 : 4;
    base = (d == 0) ? 0 : 3;
    nb = stim.size();
    acc = '0; done = 1'b0; err = 1'b0; wc = 0;
    if (nb >= 4) begin
      n = get_word(0);
      if (n > maxw) begin
        err = 1'b1;
      end else begin
        for (int unsigned i = 0; i < n && 4 * (i + 2) <= nb && i < 64; i++) begin
          w = get_word(4 + 4 * i);
          acc ^= w;
          exp_w[d][i] = {32'((base + i) % maxw), w};
          wc++;
        end
        if (nb >= 4 * (n + 2)) begin
          done = (get_word(4 + 4 * n) == acc);
          err  = !done;
        end
      end
    end
    exp_n[d]  = int'(wc);
    exp_st[d] = {done, err, !done, !(done || err), 16'(wc)};
  endtask

  task automatic do_reset();
    rst = 1'b1;
    byte_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic begin_case();
    mon_start[0] = mon_wr0.size();
    mon_start[1] = mon_wr1.size();
    model(0);
    model(1);
  endtask

  // gap < 0 selects a random 0..3 idle cycles after each byte.
  task automatic send(input int gap);
    int g;
    foreach (stim[i]) begin
      byte_in = stim[i];
      byte_valid = 1'b1;
      @(posedge clk);
      #1 byte_valid = 1'b0;
      byte_in = 8'($urandom);
      g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
      repeat (g) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic collect();
    repeat (2) @(posedge clk);
    #1;
    obs_st[0] = {dn0, er0, cr0, rdy0, 16'(wc0)};
    obs_st[1] = {dn1, er1, cr1, rdy1, 16'(wc1)};
    obs_n[0]  = mon_wr0.size() - mon_start[0];
    obs_n[1]  = mon_wr1.size() - mon_start[1];
  endtask

  task automatic test_reset();
    rst = 1'b1;
    byte_valid = 1'b1;
    byte_in = 8'hA5;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({rdy0, wen0, dn0, er0, !cr0, addr0, data0, wc0} !== '0) begin
      errors++;
      $display("FAIL reset dut0 {rdy,wen,done,err,!cpuRst,addr,data,wc} got %h want 0",
               {rdy0, wen0, dn0, er0, !cr0, addr0, data0, wc0});
    end
    checks++;
    if ({rdy1, wen1, dn1, er1, !cr1, addr1, data1, wc1} !== '0) begin
      errors++;
      $display("FAIL reset dut1 {rdy,wen,done,err,!cpuRst,addr,data,wc} got %h want 0",
               {rdy1, wen1, dn1, er1, !cr1, addr1, data1, wc1});
    end
    rst = 1'b0;
    byte_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({rdy0, rdy1} !== 2'b11) begin
      errors++;
      $display("FAIL reset_release byteReady got %b want 11", {rdy0, rdy1});
    end
  endtask

  task automatic test_two_word();
    string tag;
    for (int p = 0; p < 2; p++) begin
      tag = (p == 0) ? "two_word" : "two_word_gapped";
      do_reset();
      stim.delete();
      push_word(32'd2); push_word(32'h00500093); push_word(32'h00100113); push_word(32'h00400180);
      begin_case();
      send(p == 0 ? 0 : 3);
      if (p == 0) begin
        checks++;
        if ({dn0, cr0, rdy0} !== 3'b100) begin
          errors++;
          $display("FAIL two_word_latency {done,cpuRst,ready} got %b want 100", {dn0, cr0, rdy0});
        end
      end
      collect();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs_st[d] !== exp_st[d]) begin
          errors++;
          $display("FAIL %s dut%0d status{done,err,cpuRst,ready,wc} got %h want %h", tag, d, obs_st[d], exp_st[d]);
        end
        checks++;
        if (obs_n[d] !== exp_n[d]) begin
          errors++;
          $display("FAIL %s dut%0d write count got %0d want %0d", tag, d, obs_n[d], exp_n[d]);
        end
        for (int i = 0; i < exp_n[d] && i < obs_n[d]; i++) begin
          checks++;
          if (obs_wr(d, i) !== exp_w[d][i]) begin
            errors++;
            $display("FAIL %s dut%0d write%0d {addr,data} got %h want %h", tag, d, i, obs_wr(d, i), exp_w[d][i]);
          end
        end
      end
    end
  endtask

  task automatic test_bad_csum();
    do_reset();
    stim.delete();
    push_word(32'd2); push_word(32'h00500093); push_word(32'h00100113); push_word(32'h00400181);
    push_word(32'hDEADBEEF);
    begin_case();
    model(0);
    send(0);
    collect();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obs_st[d] !== exp_st[d]) begin
        errors++;
        $display("FAIL bad_csum dut%0d status{done,err,cpuRst,ready,wc} got %h want %h", d, obs_st[d], exp_st[d]);
      end
      checks++;
      if (obs_n[d] !== exp_n[d]) begin
        errors++;
        $display("FAIL bad_csum dut%0d write count got %0d want %0d", d, obs_n[d], exp_n[d]);
      end
      for (int i = 0; i < exp_n[d] && i < obs_n[d]; i++) begin
        checks++;
        if (obs_wr(d, i) !== exp_w[d][i]) begin
          errors++;
          $display("FAIL bad_csum dut%0d write%0d {addr,data} got %h want %h", d, i, obs_wr(d, i), exp_w[d][i]);
        end
      end
    end
  endtask

  task automatic test_oversize();
    do_reset();
    stim.delete();
    push_word(32'd5);
    begin_case();
    send(0);
    checks++;
    if ({er1, dn1, rdy1} !== 3'b100) begin
      errors++;
      $display("FAIL oversize_immediate dut1 {err,done,ready} got %b want 100", {er1, dn1, rdy1});
    end
    collect();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obs_st[d] !== exp_st[d]) begin
        errors++;
        $display("FAIL oversize dut%0d status{done,err,cpuRst,ready,wc} got %h want %h", d, obs_st[d], exp_st[d]);
      end
      checks++;
      if (obs_n[d] !== exp_n[d]) begin
        errors++;
        $display("FAIL oversize dut%0d write count got %0d want %0d", d, obs_n[d], exp_n[d]);
      end
    end
    // dut0 is mid-load in DATA: byteReady must drop as soon as rst rises.
    rst = 1'b1;
    #1;
    checks++;
    if (rdy0 !== 1'b0) begin
      errors++;
      $display("FAIL ready_during_rst dut0 byteReady got %b want 0", rdy0);
    end
  endtask

  task automatic test_empty_and_full();
    string tag;
    logic [31:0] w, acc;
    for (int p = 0; p < 2; p++) begin
      tag = (p == 0) ? "empty" : "full_tiny";
      do_reset();
      stim.delete();
      acc = '0;
      push_word((p == 0) ? 32'd0 : 32'd4);
      for (int i = 0; i < 4 * p; i++) begin
        w = $urandom;
        acc ^= w;
        push_word(w);
      end
      push_word(acc);
      begin_case();
      send(-1);
      collect();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs_st[d] !== exp_st[d]) begin
          errors++;
          $display("FAIL %s dut%0d status{done,err,cpuRst,ready,wc} got %h want %h", tag, d, obs_st[d], exp_st[d]);
        end
        checks++;
        if (obs_n[d] !== exp_n[d]) begin
          errors++;
          $display("FAIL %s dut%0d write count got %0d want %0d", tag, d, obs_n[d], exp_n[d]);
        end
        for (int i = 0; i < exp_n[d] && i < obs_n[d]; i++) begin
          checks++;
          if (obs_wr(d, i) !== exp_w[d][i]) begin
            errors++;
            $display("FAIL %s dut%0d write%0d {addr,data} got %h want %h", tag, d, i, obs_wr(d, i), exp_w[d][i]);
          end
        end
      end
    end
  endtask

  task automatic test_reset_midload();
    int low0, low1;
    do_reset();
    low0 = cr_low0;
    low1 = cr_low1;
    stim.delete();
    push_word(32'd2); push_word(32'h00500093);
    stim = stim[0:5];
    begin_case();
    send(0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    stim.delete();
    push_word(32'd2); push_word(32'h00500093); push_word(32'h00100113); push_word(32'h00400180);
    begin_case();
    send(0);
    checks++;
    if ({cr_low0, cr_low1} !== {low0, low1}) begin
      errors++;
      $display("FAIL midload cpuRst low cycles before done got %0d/%0d want 0/0", cr_low0 - low0, cr_low1 - low1);
    end
    collect();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obs_st[d] !== exp_st[d]) begin
        errors++;
        $display("FAIL midload dut%0d status{done,err,cpuRst,ready,wc} got %h want %h", d, obs_st[d], exp_st[d]);
      end
      checks++;
      if (obs_n[d] !== exp_n[d]) begin
        errors++;
        $display("FAIL midload dut%0d write count got %0d want %0d", d, obs_n[d], exp_n[d]);
      end
      for (int i = 0; i < exp_n[d] && i < obs_n[d]; i++) begin
        checks++;
        if (obs_wr(d, i) !== exp_w[d][i]) begin
          errors++;
          $display("FAIL midload dut%0d write%0d {addr,data} got %h want %h", d, i, obs_wr(d, i), exp_w[d][i]);
        end
      end
    end
  endtask

  task automatic test_random();
    int unsigned n;
    logic [31:0] w, acc;
    for (int it = 0; it < 12; it++) begin
      do_reset();
      stim.delete();
      n = $urandom_range(0, 6);
      acc = '0;
      push_word(n);
      for (int unsigned i = 0; i < n; i++) begin
        w = $urandom;
        acc ^= w;
        push_word(w);
      end
      if ($urandom_range(0, 3) == 0) acc ^= 32'(1) << $urandom_range(0, 31);
      push_word(acc);
      begin_case();
      send((it % 2 == 0) ? 0 : -1);
      collect();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs_st[d] !== exp_st[d]) begin
          errors++;
          $display("FAIL random%0d dut%0d status{done,err,cpuRst,ready,wc} got %h want %h", it, d, obs_st[d], exp_st[d]);
        end
        checks++;
        if (obs_n[d] !== exp_n[d]) begin
          errors++;
          $display("FAIL random%0d dut%0d write count got %0d want %0d", it, d, obs_n[d], exp_n[d]);
        end
        for (int i = 0; i < exp_n[d] && i < obs_n[d]; i++) begin
          checks++;
          if (obs_wr(d, i) !== exp_w[d][i]) begin
            errors++;
            $display("FAIL random%0d dut%0d write%0d {addr,data} got %h want %h", it, d, i, obs_wr(d, i), exp_w[d][i]);
          end
        end
      end
    end
  endtask

  task automatic test_invariants();
    checks++;
    if (inv_bad !== 2'b00) begin
      errors++;
      $display("FAIL invariants {dut1,dut0} done&err or cpuRst!=!done seen got %b want 00", inv_bad);
    end
  endtask

  initial begin
    test_reset();
    test_two_word();
    test_bad_csum();
    test_oversize();
    test_empty_and_full();
    test_reset_midload();
    test_random();
    test_invariants();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
Boot-time program loader that sits directly upstream of the RISC-V CPU core and its instruction RAM. It accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit words. It writes those words into instruction memory, checks an XOR checksum, and holds the CPU in reset until the program loads successfully.

Parameters:
ADDR_WIDTH, 10, word-address width of instruction memory; capacity MAX_WORDS = 2**ADDR_WIDTH
BASE_ADDR, 0, first word address written

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
byteIn  input  8  stream data byte
byteValid  input  1  byteIn is valid this cycle
byteReady  output  1  loader accepts a byte this cycle; transfer happens when byteValid && byteReady
memWEn  output  1  instruction-memory write enable, one-cycle pulse
memAddr  output  ADDR_WIDTH  word address for the write
memData  output  32  word to write
cpuRst  output  1  held high to keep the CPU in reset until the load succeeds
loadDone  output  1  load completed and checksum matched
loadErr  output  1  load failed (oversize count or checksum mismatch)
wordCount  output  ADDR_WIDTH+1  number of data words written so far

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high.
- Stream format, all fields little-endian:
  - 4-byte header N = number of data words.
  - N data words, 4 bytes each.
  - 4-byte trailer = XOR of all N data words.
- States:
  - HDR: collect the header.
  - DATA: collect data words.
  - CSUM: collect the trailer.
  - DONE: load succeeded.
  - ERR: load failed.
- Reset:
  - State goes to HDR. Byte index, word index, checksum accumulator and wordCount clear to 0.
  - Outputs: memWEn=0, memAddr=0, memData=0, cpuRst=1, loadDone=0, loadErr=0.
  - byteReady is forced to 0 while rst is high.
- byteReady = 1 in HDR, DATA and CSUM; 0 in DONE and ERR. It does not depend on byteValid.
- Bytes are assembled LSB first: byte k of a word lands in bits [8k+7:8k].
- HDR:
  - After the 4th header byte is accepted, N is latched.
  - N > MAX_WORDS: go to ERR.
  - N == 0: go to CSUM.
  - Otherwise: go to DATA.
- DATA writes:
  - On the edge that accepts the 4th byte of a word, memWEn, memAddr and memData are registered.
  - memWEn is therefore high for exactly the one following cycle, with memAddr = BASE_ADDR + index (modulo 2**ADDR_WIDTH) and memData = the assembled word.
  - wordCount increments on that same edge.
  - The checksum accumulator XORs in the word on that same edge.
  - After word N-1 is written, go to CSUM.
- Back-to-back bytes:
  - Bytes may arrive every cycle; no bubbles are required.
  - A write pulse can coincide with acceptance of the next byte.
- CSUM:
  - After the 4th trailer byte: trailer == accumulator goes to DONE; otherwise go to ERR.
- DONE and ERR are registered on the same edge that accepts the final byte.
- DONE: loadDone=1, cpuRst=0, byteReady=0. Held until rst.
- ERR: loadErr=1, cpuRst=1, byteReady=0. Held until rst. Any remaining stream bytes are ignored.
- loadDone and loadErr are never both high.
- Reset mid-load: returns to HDR on the next edge and cpuRst stays 1. Memory already written is not cleared; the host must resend the full stream.
- byteValid low pauses assembly with no timeout. Partially assembled bytes are retained.
- N == MAX_WORDS is legal and fills memory exactly.

Decomposition:
- Package loader_pkg:
  - state encoding (HDR, DATA, CSUM, DONE, ERR);
  - BYTES_PER_WORD = 4;
  - byte-index width of 2.
- Sub-module byte_assembler:
  - 2-bit byte counter plus 32-bit shift/insert register;
  - pulses wordValid with the assembled word on the 4th accepted byte;
  - has a synchronous clear.
- instr_loader holds the FSM, word index, checksum and memory write registers.

Test Plan:
- Two-word load with bytes every cycle:
  - Stimulus: 02 00 00 00 | 93 00 50 00 | 13 01 10 00 | 80 01 40 00.
  - Required: memWEn pulses with (addr 0, data 0x00500093) then (addr 1, data 0x00100113); wordCount ends at 2.
  - Required: loadDone=1 and cpuRst=0 one cycle after the last byte; byteReady=0 thereafter.
- Same stream with byteValid low for 3 cycles between every byte:
  - Required: identical writes and identical final state; no extra memWEn pulses.
- Checksum mismatch: same stream with trailer 0x00400181.
  - Required: both writes occur; then loadErr=1, loadDone=0, cpuRst=1, byteReady=0.
- Oversize header with ADDR_WIDTH=2: header 05 00 00 00.
  - Required: ERR immediately after the 4th header byte; no memWEn pulses; wordCount=0.
- Empty program: 00 00 00 00 | 00 00 00 00.
  - Required: no writes; loadDone=1, cpuRst=0.
- Reset mid-load: assert rst for 1 cycle after the 6th byte of the two-word stream, then resend the full stream.
  - Required: cpuRst stays 1 throughout; the second pass produces writes to addr 0 and 1 starting from byte index 0, then loadDone=1.
